regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard_pkg.sv | 28 ++
 rtl/regfile_scoreboard_if.sv | 29 ++
 rtl/sb_reg_counter.sv | 52 +++++
 rtl/regfile_scoreboard.sv | 114 +++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths, request payload and helpers for the register-file scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned SB_CNT_W      = 2;
  localparam int unsigned INFLIGHT_W    = 7;
  localparam int unsigned STALL_W       = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Decode-side request as seen by the scoreboard
  typedef struct packed {
    logic      valid;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      uses_rs1;
    logic      uses_rs2;
    logic      writes_rd;
  } rv32_sb_req_t;

  // True when an operand slot refers to a tracked register (x0 never is)
  function automatic logic tracked(input logic used, input reg_addr_t addr);
    return used && (addr != '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/issue handshake plus the writeback and flush observations.
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  logic      id_valid;
  logic      id_ready;
  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  reg_addr_t id_rd;
  logic      id_uses_rs1;
  logic      id_uses_rs2;
  logic      id_writes_rd;
  logic      wb_valid;
  reg_addr_t wb_addr;
  logic      flush;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_writes_rd,
    output wb_valid, wb_addr, flush,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_writes_rd,
    input  wb_valid, wb_addr, flush,
    output id_ready
  );

endinterface

// File: rtl/sb_reg_counter.sv
// Pending-write counter for one architectural register.
module sb_reg_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             nonzero_o,
  output logic             full_o,
  output logic             underflow_c_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             nonzero_q, full_q;

  // Next count: clear wins, inc+dec cancel, a decrement at zero only flags
  always_comb begin
    count_d       = count_q;
    underflow_c_o = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i) begin
      if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) underflow_c_o = 1'b1;
      else               count_d = count_q - CNT_W'(1);
    end
  end

  // Count and its decoded flags are all registered
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      nonzero_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      nonzero_q <= (count_d != '0);
      full_q    <= (count_d == CNT_MAX);
    end
  end

  assign count_o   = count_q;
  assign nonzero_o = nonzero_q;
  assign full_o    = full_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// In-order issue scoreboard: holds decode while a source is pending or rd is saturated.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_ARCH_REGS,
  parameter int unsigned CNT_W    = SB_CNT_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  regfile_scoreboard_if.slave   sb_if,
  output logic [NUM_REGS-1:0]   busy_vec_o,
  output logic [INFLIGHT_W-1:0] inflight_o,
  output logic [STALL_W-1:0]    stall_cycles_o,
  output logic                  err_underflow_o
);

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  rv32_sb_req_t req;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nonzero;
  logic [NUM_REGS-1:0] full;
  logic [NUM_REGS-1:0] uflow;

  logic hz_src, hz_dst;
  logic issue_fire, track_inc, wb_dec, err_hit, dec_ok;

  logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
  logic [STALL_W-1:0]    stall_q, stall_d;
  logic                  err_q, err_d;

  // Pack the decode fields into the request payload
  assign req = '{valid:     sb_if.id_valid,
                 rs1:       sb_if.id_rs1,
                 rs2:       sb_if.id_rs2,
                 rd:        sb_if.id_rd,
                 uses_rs1:  sb_if.id_uses_rs1,
                 uses_rs2:  sb_if.id_uses_rs2,
                 writes_rd: sb_if.id_writes_rd};

  // x0 has no storage and is never busy
  assign cnt[0]     = '0;
  assign nonzero[0] = 1'b0;
  assign full[0]    = 1'b0;
  assign uflow[0]   = 1'b0;

  // Hazards come only from registered counters, so a same-cycle writeback never bypasses
  assign hz_src = (tracked(req.uses_rs1, req.rs1) && (cnt[req.rs1] != '0)) ||
                  (tracked(req.uses_rs2, req.rs2) && (cnt[req.rs2] != '0));
  assign hz_dst = tracked(req.writes_rd, req.rd) && full[req.rd];

  assign sb_if.id_ready = !hz_src && !hz_dst && !sb_if.flush;

  assign issue_fire = req.valid && sb_if.id_ready;
  assign track_inc  = issue_fire && tracked(req.writes_rd, req.rd);
  assign wb_dec     = sb_if.wb_valid && (sb_if.wb_addr != '0) && !sb_if.flush;
  assign err_hit    = |uflow;
  assign dec_ok     = wb_dec && !err_hit;

  // One pending-write counter per tracked register
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    logic inc, dec;
    assign inc = track_inc && (req.rd == REG_ADDR_W'(i));
    assign dec = wb_dec && (sb_if.wb_addr == REG_ADDR_W'(i));

    sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk          (clk),
      .resetn       (resetn),
      .inc_i        (inc),
      .dec_i        (dec),
      .clr_i        (sb_if.flush),
      .count_o      (cnt[i]),
      .nonzero_o    (nonzero[i]),
      .full_o       (full[i]),
      .underflow_c_o(uflow[i])
    );
  end

  // Inflight tracks issue/retire deltas; stall count saturates; error is sticky
  always_comb begin
    inflight_d = inflight_q;
    stall_d    = stall_q;
    err_d      = err_q;
    if (sb_if.flush) begin
      inflight_d = '0;
    end else begin
      inflight_d = inflight_q + INFLIGHT_W'(track_inc) - INFLIGHT_W'(dec_ok);
    end
    if (req.valid && !sb_if.id_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_W'(1);
    end
    if (err_hit) err_d = 1'b1;
  end

  // Status registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_q <= '0;
      stall_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  assign busy_vec_o      = nonzero;
  assign inflight_o      = inflight_q;
  assign stall_cycles_o  = stall_q;
  assign err_underflow_o = err_q;

endmodule
